serial_subtractor: RTL and testbench

Parametrised bit-serial N-bit subtractor computing A − B − borrow_in, one bit per clock, LSB first. It is built around a single one-bit full-subtractor cell and a borrow flip-flop, trading latency for area. A start/busy/done handshake lets a controller issue operands and collect the registered difference, final borrow and zero flag. It is the sequential, width-generic successor to the team's combinational half-subtractor.

---
 rtl/sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the constant function used to size the bit counter.
package sub_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Ceiling log2; callers guarantee value >= 2 so the result is at least 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing a - b - borrow_in, LSB first,
// one bit per clock through a single full-subtractor cell.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int                CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        br_d         = br_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {cell_d, res_q[WIDTH-1:1]};
                br_d  = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed result including this bit.
                    diff_d       = res_d;
                    borrow_out_d = cell_bout;
                    zero_d       = (res_d == '0);
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            br_q         <= br_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic        start8, bin8, busy8, done8, bo8, zero8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, bin16, busy16, done16, bo16, zero16;
    logic [15:0] a16, b16, diff16;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  last8  = 8'h00;
    logic [15:0] last16 = 16'h0000;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .borrow_in  (bin8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .zero       (zero8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start16),
        .a          (a16),
        .b          (b16),
        .borrow_in  (bin16),
        .busy       (busy16),
        .done       (done16),
        .diff       (diff16),
        .borrow_out (bo16),
        .zero       (zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w16, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic binv);
        if (w16) begin
            start16 = s; a16 = av; b16 = bv; bin16 = binv;
        end else begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; bin8 = binv;
        end
    endtask

    // Entered #1 into an IDLE cycle (cycle 0); returns #1 into the next IDLE cycle.
    task automatic run_op(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                          input logic binv, input logic [15:0] exp_d,
                          input logic exp_bo, input logic exp_z);
        int w;
        logic [15:0] held;
        w    = w16 ? 16 : 8;
        held = w16 ? last16 : {8'h00, last8};
        drive(w16, 1'b1, av, bv, binv);
        @(posedge clk); #1;
        drive(w16, 1'b0, 16'($urandom), 16'($urandom), ~binv);
        for (int c = 1; c <= w; c++) begin
            chk1("busy_shift", w16 ? busy16 : busy8, 1'b1);
            chk1("done_shift", w16 ? done16 : done8, 1'b0);
            chk16("diff_hold", w16 ? diff16 : {8'h00, diff8}, held);
            @(posedge clk); #1;
        end
        chk1("done_pulse", w16 ? done16 : done8, 1'b1);
        chk1("busy_done", w16 ? busy16 : busy8, 1'b0);
        chk16("diff", w16 ? diff16 : {8'h00, diff8}, exp_d);
        chk1("borrow_out", w16 ? bo16 : bo8, exp_bo);
        chk1("zero", w16 ? zero16 : zero8, exp_z);
        if (w16) last16 = exp_d; else last8 = exp_d[7:0];
        @(posedge clk); #1;
        chk1("done_idle", w16 ? done16 : done8, 1'b0);
        chk1("busy_idle", w16 ? busy16 : busy8, 1'b0);
    endtask

    initial begin
        logic [15:0] av, bv;
        logic        binv;
        logic [16:0] r;
        logic [8:0]  r9;
        logic [7:0]  qa [30];
        logic [7:0]  qb [30];
        logic        qbin [30];
        int          n_done;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        chk1("rst_busy8", busy8, 1'b0);
        chk1("rst_done8", done8, 1'b0);
        chk16("rst_diff8", {8'h00, diff8}, 16'h0000);
        chk1("rst_bo8", bo8, 1'b0);
        chk1("rst_zero8", zero8, 1'b0);
        chk16("rst_diff16", diff16, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed 8-bit vectors.
        run_op(1'b0, 16'd10,   16'd3,    1'b0, 16'h0007, 1'b0, 1'b0);
        run_op(1'b0, 16'd3,    16'd10,   1'b0, 16'h00F9, 1'b1, 1'b0);
        run_op(1'b0, 16'h0055, 16'h0055, 1'b0, 16'h0000, 1'b0, 1'b1);
        run_op(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1'b0);
        run_op(1'b0, 16'h0000, 16'h00FF, 1'b1, 16'h0000, 1'b1, 1'b1);
        run_op(1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h00FE, 1'b0, 1'b0);

        // start held high with fresh operands every cycle: accepts at 0, 10, 20.
        n_done = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done8) n_done++;
            if (cyc % 10 == 9) begin
                r9 = {1'b0, qa[cyc-9]} - {1'b0, qb[cyc-9]} - 9'(qbin[cyc-9]);
                chk1("stream_done", done8, 1'b1);
                chk16("stream_diff", {8'h00, diff8}, {8'h00, r9[7:0]});
                chk1("stream_bo", bo8, r9[8]);
                chk1("stream_zero", zero8, r9[7:0] == 8'h00);
                last8 = r9[7:0];
            end
            qa[cyc]   = 8'($urandom);
            qb[cyc]   = 8'($urandom);
            qbin[cyc] = 1'($urandom);
            drive(1'b0, 1'b1, {8'h00, qa[cyc]}, {8'h00, qb[cyc]}, qbin[cyc]);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk16("stream_pulses", 16'(n_done), 16'd3);

        // Reset in cycle 4 of an operation aborts it without a done pulse.
        drive(1'b0, 1'b1, 16'h0012, 16'h0034, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk1("pre_rst_busy", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy8, 1'b0);
        chk1("abort_done", done8, 1'b0);
        chk16("abort_diff", {8'h00, diff8}, 16'h0000);
        chk1("abort_bo", bo8, 1'b0);
        chk1("abort_zero", zero8, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        last8  = 8'h00;
        last16 = 16'h0000;
        n_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) n_done++;
        end
        chk16("abort_no_done", 16'(n_done), 16'd0);
        run_op(1'b0, 16'd200, 16'd100, 1'b0, 16'd100, 1'b0, 1'b0);

        // 16-bit directed and random.
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            av   = 16'($urandom);
            bv   = 16'($urandom);
            binv = 1'($urandom);
            r    = {1'b0, av} - {1'b0, bv} - 17'(binv);
            run_op(1'b1, av, bv, binv, r[15:0], r[16], r[15:0] == 16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
